gpio_hilo_unit: RTL and testbench
=================================

// Module: gpio_hilo_unit
// PURPOSE
//  Execute/writeback-side responder to the control unit's decode outputs. Owns
//  the HI/LO multiply result registers, the GPIO output latch and the
//  synchronised, debounced GPIO input. Selects and registers the writeback
//  data for mfhi/mflo/GPIO-read/ALU results. Sits between the EX-stage ALU and
//  the register-file write port.
// PARAMETERS
//  GPIO_WIDTH       8   Number of GPIO pins in each direction (1..32).
//  DEBOUNCE_CYCLES  4   Consecutive cycles an input change must persist before it is accepted (>=1).
// PORTS
//  clk              in   1           System clock, rising edge.
//  rst              in   1           Reset: asynchronous, active-high.
//  enhilo_EX        in   1           Load HI/LO from the multiplier outputs (mult/multu).
//  regsel_EX        in   2           00: ALU result, 01: HI (or GPIO when GPIO_IN), 10: LO, 11: ALU result.
//  regwrite_EX      in   1           Register-file write enable from decode.
//  GPIO_OUT         in   1           Latch alu_result_EX into the GPIO output register.
//  GPIO_IN          in   1           Writeback takes the debounced GPIO input (valid with regsel_EX=01).
//  alu_result_EX    in   32          ALU result.
//  alu_hi_EX        in   32          Upper 32 bits of the multiplier product.
//  alu_lo_EX        in   32          Lower 32 bits of the multiplier product.
//  gpio_pins_in     in   GPIO_WIDTH  Asynchronous board inputs.
//  gpio_pins_out    out  GPIO_WIDTH  Registered board outputs.
//  writedata_WB     out  32          Registered writeback data.
//  regwrite_WB      out  1           regwrite_EX delayed by one cycle.
//  gpio_in_changed  out  1           One-cycle pulse when the debounced input value updates.
// BEHAVIOUR
//  Reset (async, rst=1): HI, LO, gpio_pins_out, writedata_WB, regwrite_WB,
//   gpio_in_changed, both sync stages, debounced value and counter all go to 0.
//   Asserting rst mid-debounce discards the pending change.
//  HI/LO: on a rising edge with enhilo_EX=1, HI<=alu_hi_EX and LO<=alu_lo_EX.
//   Otherwise they hold their value.
//  Writeback mux (combinational, registered on the clock edge):
//   GPIO_IN=1 && regsel_EX=01 -> {zero-extend, debounced}
//   regsel_EX=01 -> HI
//   regsel_EX=10 -> LO
//   otherwise -> alu_result_EX
//   GPIO_IN=1 with regsel_EX!=01 is ignored; the normal regsel decode applies.
//   writedata_WB and regwrite_WB update every edge: 1-cycle latency, no stall.
//  Same-edge hazard: when enhilo_EX=1 and regsel_EX=01/10 in the same cycle, the
//   mux uses the pre-edge (old) HI/LO. A mfhi/mflo in the cycle after a mult sees
//   the new values.
//  GPIO out: on an edge with GPIO_OUT=1, gpio_pins_out <= alu_result_EX[GPIO_WIDTH-1:0].
//   Otherwise it holds its value. Upper bits are dropped.
//  GPIO in:
//   - 2-flop synchroniser: sync1 <= pins, sync2 <= sync1.
//   - Debounce counter cnt, width clog2(DEBOUNCE_CYCLES)+1:
//     sync2==deb -> cnt <= 0.
//     sync2!=deb and cnt < DEBOUNCE_CYCLES-1 -> cnt++.
//     sync2!=deb and cnt == DEBOUNCE_CYCLES-1 -> deb <= sync2, cnt <= 0,
//       gpio_in_changed=1 for that one following cycle.
//   - A glitch shorter than DEBOUNCE_CYCLES resets cnt and is never accepted.
//   - A pin changing to a new value mid-count keeps cnt running, because it still
//     differs from deb. The accepted value is sync2 at the accept edge.
//   - Latency from a pin change to the deb update: 2 + DEBOUNCE_CYCLES edges.
//  HI/LO, GPIO output and writeback paths are independent. Simultaneous
//   enhilo_EX, GPIO_OUT and GPIO_IN all take effect on the same edge.
// TESTING
//  1 Assert rst mid-run, async to clk -> all outputs 0 immediately; deassert ->
//    outputs stay 0 until stimulus arrives.
//  2 enhilo_EX=1, alu_hi_EX=32'h00000001, alu_lo_EX=32'hFFFF0000; next cycle
//    regsel_EX=01, regwrite_EX=1 -> writedata_WB=32'h00000001, regwrite_WB=1
//    one edge later. Then regsel_EX=10 -> 32'hFFFF0000.
//  3 Drive enhilo_EX=1 (new HI=32'h5) and regsel_EX=01 in the same cycle ->
//    writedata_WB = old HI. On the next cycle, regsel_EX=01 -> 32'h5.
//  4 GPIO_OUT=1, alu_result_EX=32'h000001A5 -> gpio_pins_out=8'hA5 after the edge.
//    Then GPIO_OUT=0 with alu_result_EX=32'h0 -> stays 8'hA5.
//  5 gpio_pins_in 8'h00->8'h3C held -> deb=8'h3C and a single gpio_in_changed
//    pulse after 6 edges. A 3-cycle pulse to 8'hFF -> no change, no pulse.
//  6 deb=8'h3C with HI=32'h5, GPIO_IN=1, regsel_EX=01 -> writedata_WB=32'h0000003C
//    (not HI). rst asserted during a pending change -> deb stays 0.

Source files
------------

// File: rtl/gpio_hilo_unit.sv
// rtl/gpio_hilo_unit.sv - HI/LO registers, GPIO latch/debouncer and registered writeback select
module gpio_hilo_unit #(
    parameter int GPIO_WIDTH      = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enhilo_EX,
    input  logic [1:0]            regsel_EX,
    input  logic                  regwrite_EX,
    input  logic                  GPIO_OUT,
    input  logic                  GPIO_IN,
    input  logic [31:0]           alu_result_EX,
    input  logic [31:0]           alu_hi_EX,
    input  logic [31:0]           alu_lo_EX,
    input  logic [GPIO_WIDTH-1:0] gpio_pins_in,
    output logic [GPIO_WIDTH-1:0] gpio_pins_out,
    output logic [31:0]           writedata_WB,
    output logic                  regwrite_WB,
    output logic                  gpio_in_changed
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [31:0]           hi_reg;
    logic [31:0]           lo_reg;
    logic [GPIO_WIDTH-1:0] sync1;
    logic [GPIO_WIDTH-1:0] sync2;
    logic [GPIO_WIDTH-1:0] deb;
    logic [CNT_W-1:0]      cnt;
    logic [31:0]           deb_ext;
    logic [31:0]           wb_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (enhilo_EX) begin
            hi_reg <= alu_hi_EX;
            lo_reg <= alu_lo_EX;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio_pins_out <= '0;
        end else if (GPIO_OUT) begin
            gpio_pins_out <= alu_result_EX[GPIO_WIDTH-1:0];
        end
    end

    // Width-safe zero extension, also valid when GPIO_WIDTH is 32.
    always_comb begin
        deb_ext = '0;
        deb_ext[GPIO_WIDTH-1:0] = deb;
    end

    // Reads the pre-edge HI/LO, so a same-cycle mult is not forwarded.
    always_comb begin
        wb_next = alu_result_EX;
        if (regsel_EX == 2'b01) begin
            wb_next = GPIO_IN ? deb_ext : hi_reg;
        end else if (regsel_EX == 2'b10) begin
            wb_next = lo_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            writedata_WB <= '0;
            regwrite_WB  <= 1'b0;
        end else begin
            writedata_WB <= wb_next;
            regwrite_WB  <= regwrite_EX;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= gpio_pins_in;
            sync2 <= sync1;
        end
    end

    // Any difference from the accepted value keeps counting, even if the pins move again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb             <= '0;
            cnt             <= '0;
            gpio_in_changed <= 1'b0;
        end else begin
            gpio_in_changed <= 1'b0;
            if (sync2 == deb) begin
                cnt <= '0;
            end else if (cnt < CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end else begin
                deb             <= sync2;
                cnt             <= '0;
                gpio_in_changed <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gpio_hilo_unit.sv
// tb/tb_gpio_hilo_unit.sv - directed self-checking bench for gpio_hilo_unit
module tb_gpio_hilo_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        enhilo_EX;
    logic [1:0]  regsel_EX;
    logic        regwrite_EX;
    logic        GPIO_OUT;
    logic        GPIO_IN;
    logic [31:0] alu_result_EX;
    logic [31:0] alu_hi_EX;
    logic [31:0] alu_lo_EX;
    logic [7:0]  gpio_pins_in;
    logic [7:0]  gpio_pins_out;
    logic [31:0] writedata_WB;
    logic        regwrite_WB;
    logic        gpio_in_changed;

    int n_checks = 0;
    int n_fail   = 0;

    gpio_hilo_unit #(.GPIO_WIDTH(8), .DEBOUNCE_CYCLES(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .enhilo_EX       (enhilo_EX),
        .regsel_EX       (regsel_EX),
        .regwrite_EX     (regwrite_EX),
        .GPIO_OUT        (GPIO_OUT),
        .GPIO_IN         (GPIO_IN),
        .alu_result_EX   (alu_result_EX),
        .alu_hi_EX       (alu_hi_EX),
        .alu_lo_EX       (alu_lo_EX),
        .gpio_pins_in    (gpio_pins_in),
        .gpio_pins_out   (gpio_pins_out),
        .writedata_WB    (writedata_WB),
        .regwrite_WB     (regwrite_WB),
        .gpio_in_changed (gpio_in_changed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pins_out"}, 32'(gpio_pins_out), 32'h0);
        check({tag, "_wdata"}, writedata_WB, 32'h0);
        check({tag, "_regwrite"}, 32'(regwrite_WB), 32'h0);
        check({tag, "_changed"}, 32'(gpio_in_changed), 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        enhilo_EX = 1'b0; regsel_EX = 2'b00; regwrite_EX = 1'b0;
        GPIO_OUT = 1'b0; GPIO_IN = 1'b0;
        alu_result_EX = '0; alu_hi_EX = '0; alu_lo_EX = '0;
        gpio_pins_in = 8'h00;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // mult then mfhi / mflo
        enhilo_EX = 1'b1; alu_hi_EX = 32'h0000_0001; alu_lo_EX = 32'hFFFF_0000;
        tick();
        check("mult_wdata", writedata_WB, 32'h0);
        enhilo_EX = 1'b0; regsel_EX = 2'b01; regwrite_EX = 1'b1;
        tick();
        check("mfhi", writedata_WB, 32'h0000_0001);
        check("mfhi_regwrite", 32'(regwrite_WB), 32'h1);
        regsel_EX = 2'b10;
        tick();
        check("mflo", writedata_WB, 32'hFFFF_0000);

        // same-edge hazard returns old HI
        enhilo_EX = 1'b1; alu_hi_EX = 32'h5; alu_lo_EX = 32'h7; regsel_EX = 2'b01;
        tick();
        check("hazard_old_hi", writedata_WB, 32'h0000_0001);
        enhilo_EX = 1'b0;
        tick();
        check("new_hi", writedata_WB, 32'h5);

        // GPIO out latch, upper bits dropped
        regsel_EX = 2'b00; GPIO_OUT = 1'b1; alu_result_EX = 32'h0000_01A5; regwrite_EX = 1'b1;
        tick();
        check("gpio_out", 32'(gpio_pins_out), 32'hA5);
        check("alu_wdata", writedata_WB, 32'h0000_01A5);
        GPIO_OUT = 1'b0; alu_result_EX = 32'h0;
        tick();
        check("gpio_out_hold", 32'(gpio_pins_out), 32'hA5);
        regsel_EX = 2'b11; alu_result_EX = 32'h1234_5678;
        tick();
        check("regsel11_alu", writedata_WB, 32'h1234_5678);

        // asynchronous reset mid-cycle
        #3 rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        #2 rst = 1'b0;
        regsel_EX = 2'b00; alu_result_EX = 32'h0; regwrite_EX = 1'b0;
        tick();
        tick();
        check_all_zero("post_rst");

        // reload HI so GPIO reads are distinguishable from HI
        enhilo_EX = 1'b1; alu_hi_EX = 32'h5; alu_lo_EX = 32'h0;
        tick();
        enhilo_EX = 1'b0; GPIO_IN = 1'b1; regsel_EX = 2'b01;
        tick();
        check("gpio_rd_init", writedata_WB, 32'h0);

        // accept after 2 + 4 edges, single pulse
        gpio_pins_in = 8'h3C;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("deb_chg_e%0d", k), 32'(gpio_in_changed), (k == 6) ? 32'h1 : 32'h0);
            check($sformatf("deb_wd_e%0d", k), writedata_WB, (k >= 7) ? 32'h3C : 32'h0);
        end

        // 3-cycle glitch is rejected
        gpio_pins_in = 8'hFF;
        tick(); tick(); tick();
        gpio_pins_in = 8'h3C;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("glitch_chg_%0d", k), 32'(gpio_in_changed), 32'h0);
        end
        check("glitch_wd", writedata_WB, 32'h3C);
        GPIO_IN = 1'b0;
        tick();
        check("gpio_in_off_hi", writedata_WB, 32'h5);

        // reset during pending change discards it
        GPIO_IN = 1'b1;
        gpio_pins_in = 8'h81;
        tick(); tick(); tick(); tick();
        #2 rst = 1'b1;
        gpio_pins_in = 8'h00;
        #1;
        check_all_zero("pend_rst");
        #2 rst = 1'b0;
        enhilo_EX = 1'b1; alu_hi_EX = 32'h5;
        tick();
        enhilo_EX = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("pend_chg_%0d", k), 32'(gpio_in_changed), 32'h0);
        end
        check("pend_deb_zero", writedata_WB, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
